sr_scan_ctrl: RTL

//  Sequencer for the shift-register (74HC595-style) display chain driven from the frame buffer.
//  Per column: fetches one word from frame-buffer RAM, shifts it MSB-first on serial_data/sclk, pulses rclk.

---
 rtl/sr_scan_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sr_scan_ctrl.sv
// sr_scan_ctrl: sequencer for a 74HC595-style shift-register display chain.
// For each column it reads one word from the frame buffer, shifts it out MSB-first on
// serial_data/sclk, pulses rclk to latch it, and then advances the column index.
// Optional feature macro: SR_SCAN_BLANK_EN drives oe_n high while the chain is being updated.
module sr_scan_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COL_W    = 6,
    parameter int unsigned NUM_COLS = 64,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fb_rd,
    output logic [COL_W-1:0]  fb_addr,
    input  logic [DATA_W-1:0] fb_rdata,
    output logic              serial_data,
    output logic              sclk,
    output logic              rclk,
    output logic              oe_n,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned TW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TW-1:0]    TimerLoad = TW'(SCLK_DIV - 1);
    localparam logic [CW-1:0]    CountLoad = CW'(DATA_W - 1);
    localparam logic [COL_W-1:0] LastCol   = COL_W'(NUM_COLS - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StShLo  = 3'd3;
    localparam logic [2:0] StShHi  = 3'd4;
    localparam logic [2:0] StLatch = 3'd5;
    localparam logic [2:0] StNext  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [COL_W-1:0]  column_q, column_d;
    logic              serial_q, serial_d;
    logic              frame_done_q, frame_done_d;
    logic              phase_done;

    assign phase_done = (timer_q == '0);

    // Next-state logic: FSM, phase timer, shift register and column index
    always_comb begin
        state_d      = state_q;
        timer_d      = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        count_d      = count_q;
        shreg_d      = shreg_q;
        column_d     = column_q;
        serial_d     = serial_q;
        frame_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) state_d = StFetch;
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                // Read data is valid in the cycle after the fetch strobe
                shreg_d = fb_rdata;
                count_d = CountLoad;
                state_d = StShLo;
            end
            StShLo: begin
                if (phase_done) state_d = StShHi;
            end
            StShHi: begin
                if (phase_done) begin
                    if (count_q == '0) begin
                        state_d = StLatch;
                    end else begin
                        shreg_d = shreg_q << 1;
                        count_d = count_q - CW'(1);
                        state_d = StShLo;
                    end
                end
            end
            StLatch: begin
                if (phase_done) state_d = StNext;
            end
            StNext: begin
                column_d     = (column_q == LastCol) ? '0 : column_q + COL_W'(1);
                frame_done_d = (column_q == LastCol);
                state_d      = enable ? StFetch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every state entry starts a fresh phase
        if (state_d != state_q) timer_d = TimerLoad;

        // Data only changes on entry to the low phase, giving a full phase of setup
        if ((state_d == StShLo) && (state_q != StShLo)) serial_d = shreg_d[DATA_W-1];
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            count_q      <= '0;
            shreg_q      <= '0;
            column_q     <= '0;
            serial_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            column_q     <= column_d;
            serial_q     <= serial_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_rd       = (state_q == StFetch);
    assign fb_addr     = column_q;
    assign serial_data = serial_q;
    assign sclk        = (state_q == StShHi);
    assign rclk        = (state_q == StLatch);
    assign busy        = (state_q != StIdle);
    assign frame_done  = frame_done_q;

`ifdef SR_SCAN_BLANK_EN
    // Blank the chain from fetch until the latch pulse ends
    assign oe_n = (state_q != StIdle) && (state_q != StNext);
`else
    assign oe_n = 1'b0;
`endif

endmodule
